// File: rtl/ftdi_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_fifo_responder
// Purpose  : Device-side FT245-style asynchronous byte FIFO model. Answers the
//            host's rd_n/wr_n strobes from an internal TX/RX FIFO pair.
// Revision : 1.0 - initial release
// ============================================================================
module ftdi_fifo_responder #(
    parameter int DEPTH     = 16,
    parameter int PRECHARGE = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic [7:0]               adbus_in,
    output logic [7:0]               adbus_out,
    output logic                     adbus_oe,
    output logic                     rxf_n,
    output logic                     txe_n,
    input  logic [7:0]               src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic [7:0]               snk_data,
    output logic                     snk_valid,
    input  logic                     snk_ready,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     protocol_err
);

    localparam int               c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full = (c_aw+1)'(DEPTH);
    localparam logic [3:0]       c_pre  = 4'(PRECHARGE);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_DRIVE = 2'd1, R_PRE = 2'd2} rstate_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_LOW = 2'd1, W_PRE = 2'd2} wstate_t;

    rstate_t          r_rstate;
    wstate_t          r_wstate;
    logic [3:0]       r_rcnt;
    logic [3:0]       r_wcnt;
    logic             r_rd_has_byte;
    logic             r_live;

    logic             r_rd_meta, r_rd_sync, r_rd_prev, r_rd_arm;
    logic             r_wr_meta, r_wr_sync, r_wr_prev, r_wr_arm;
    logic [7:0]       r_ad_meta, r_ad_sync;

    logic [7:0]       r_tx_mem [DEPTH];
    logic [7:0]       r_rx_mem [DEPTH];
    logic [c_aw-1:0]  r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [c_aw:0]    r_tx_count, r_rx_count;

    logic             w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise, w_both_low;
    logic             w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic             w_tx_nonempty, w_rx_not_full, w_err;

    // Sync flops reset low so a strobe must be seen high before a fall counts;
    // this ignores a strobe still held low when reset releases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_meta <= 1'b0; r_rd_sync <= 1'b0; r_rd_prev <= 1'b0; r_rd_arm <= 1'b0;
            r_wr_meta <= 1'b0; r_wr_sync <= 1'b0; r_wr_prev <= 1'b0; r_wr_arm <= 1'b0;
            r_ad_meta <= 8'h00; r_ad_sync <= 8'h00;
            r_live    <= 1'b0;
        end else begin
            r_rd_meta <= rd_n;      r_rd_sync <= r_rd_meta; r_rd_prev <= r_rd_sync;
            r_rd_arm  <= r_rd_arm | r_rd_sync;
            r_wr_meta <= wr_n;      r_wr_sync <= r_wr_meta; r_wr_prev <= r_wr_sync;
            r_wr_arm  <= r_wr_arm | r_wr_sync;
            r_ad_meta <= adbus_in;  r_ad_sync <= r_ad_meta;
            r_live    <= 1'b1;
        end
    end

    assign w_rd_fall  = r_rd_prev & ~r_rd_sync;
    assign w_rd_rise  = ~r_rd_prev & r_rd_sync;
    assign w_wr_fall  = r_wr_prev & ~r_wr_sync;
    assign w_wr_rise  = ~r_wr_prev & r_wr_sync;
    assign w_both_low = r_rd_arm & r_wr_arm & ~r_rd_sync & ~r_wr_sync;

    assign w_tx_nonempty = (r_tx_count != '0);
    assign w_rx_not_full = (r_rx_count != c_full);

    assign src_ready = r_live & (r_tx_count != c_full);
    assign w_tx_push = src_valid & src_ready;
    assign w_tx_pop  = (r_rstate == R_DRIVE) & w_rd_rise & r_rd_has_byte;

    assign snk_valid = (r_rx_count != '0);
    assign snk_data  = snk_valid ? r_rx_mem[r_rx_rptr] : 8'h00;
    assign w_rx_pop  = snk_valid & snk_ready;
    assign w_rx_push = (r_wstate == W_LOW) & w_wr_rise & w_rx_not_full;

    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;

    always_ff @(posedge clock) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= src_data;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_ad_sync;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rstate      <= R_IDLE;
            r_rcnt        <= 4'd0;
            r_rd_has_byte <= 1'b0;
            adbus_out     <= 8'h00;
            adbus_oe      <= 1'b0;
            rxf_n         <= 1'b1;
        end else begin
            rxf_n <= ~((r_rstate == R_IDLE) && w_tx_nonempty);
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_fall) begin
                        r_rstate      <= R_DRIVE;
                        adbus_oe      <= 1'b1;
                        r_rd_has_byte <= w_tx_nonempty;
                        adbus_out     <= w_tx_nonempty ? r_tx_mem[r_tx_rptr] : 8'h00;
                    end
                end
                R_DRIVE: begin
                    if (w_rd_rise) begin
                        r_rstate <= R_PRE;
                        adbus_oe <= 1'b0;
                        r_rcnt   <= c_pre;
                    end
                end
                R_PRE: begin
                    r_rcnt <= r_rcnt - 1'b1;
                    if (r_rcnt == 4'd1) r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // A write that overlaps a read is abandoned; its later rise is seen in W_IDLE and ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= 4'd0;
            txe_n    <= 1'b1;
        end else begin
            txe_n <= ~((r_wstate == W_IDLE) && w_rx_not_full);
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_fall && !w_both_low) r_wstate <= W_LOW;
                end
                W_LOW: begin
                    if (w_both_low) begin
                        r_wstate <= W_IDLE;
                    end else if (w_wr_rise) begin
                        r_wstate <= W_PRE;
                        r_wcnt   <= c_pre;
                    end
                end
                W_PRE: begin
                    r_wcnt <= r_wcnt - 1'b1;
                    if (r_wcnt == 4'd1) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign w_err = ((r_rstate == R_IDLE) & w_rd_fall & ~w_tx_nonempty)
                 | ((r_rstate == R_PRE)  & w_rd_fall)
                 | ((r_wstate == W_LOW)  & w_wr_rise & ~w_rx_not_full)
                 | ((r_wstate == W_PRE)  & w_wr_fall)
                 | w_both_low;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   protocol_err <= 1'b0;
        else if (w_err) protocol_err <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_ftdi_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftdi_fifo_responder
// Purpose  : Directed self-checking bench for ftdi_fifo_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftdi_fifo_responder;

    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] adbus_in = 8'h00;
    logic [7:0] adbus_out;
    logic       adbus_oe;
    logic       rxf_n;
    logic       txe_n;
    logic [7:0] src_data = 8'h00;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] snk_data;
    logic       snk_valid;
    logic       snk_ready = 1'b0;
    logic [4:0] tx_count;
    logic [4:0] rx_count;
    logic       protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    ftdi_fifo_responder #(.DEPTH(DEPTH), .PRECHARGE(PRE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_n         (rd_n),
        .wr_n         (wr_n),
        .adbus_in     (adbus_in),
        .adbus_out    (adbus_out),
        .adbus_oe     (adbus_oe),
        .rxf_n        (rxf_n),
        .txe_n        (txe_n),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .snk_data     (snk_data),
        .snk_valid    (snk_valid),
        .snk_ready    (snk_ready),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
    endtask

    // 4-clock rd_n pulse; oe is expected exactly 3 edges after each strobe change
    task automatic host_read(input logic [7:0] exp, input string tag);
        rd_n = 1'b0;
        tick();
        tick();
        chk_val({tag, "_oe_early"}, 32'(adbus_oe), 32'd0);
        tick();
        chk_val({tag, "_oe"}, 32'(adbus_oe), 32'd1);
        chk_val({tag, "_data"}, 32'(adbus_out), 32'(exp));
        tick();
        rd_n = 1'b1;
        repeat (3) tick();
        chk_val({tag, "_oe_off"}, 32'(adbus_oe), 32'd0);
    endtask

    task automatic host_write(input logic [7:0] b);
        adbus_in = b;
        wr_n = 1'b0;
        repeat (4) tick();
        wr_n = 1'b1;
        repeat (3) tick();
        repeat (PRE + 2) tick();
    endtask

    task automatic push_src(input logic [7:0] b);
        src_valid = 1'b1;
        src_data  = b;
        tick();
        src_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] exp_rx [3];
        exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h33;

        // Reset state
        repeat (3) tick();
        chk_val("rst_rxf_n", 32'(rxf_n), 32'd1);
        chk_val("rst_txe_n", 32'(txe_n), 32'd1);
        chk_val("rst_oe", 32'(adbus_oe), 32'd0);
        chk_val("rst_adbus_out", 32'(adbus_out), 32'd0);
        chk_val("rst_src_ready", 32'(src_ready), 32'd0);
        chk_val("rst_snk_valid", 32'(snk_valid), 32'd0);
        chk_val("rst_tx_count", 32'(tx_count), 32'd0);
        chk_val("rst_rx_count", 32'(rx_count), 32'd0);
        chk_val("rst_err", 32'(protocol_err), 32'd0);
        reset_n = 1'b1;
        tick();
        chk_val("rel_txe_n", 32'(txe_n), 32'd0);
        chk_val("rel_src_ready", 32'(src_ready), 32'd1);

        // Source pushes, host reads back
        src_valid = 1'b1;
        src_data  = 8'hA5;
        tick();
        src_data  = 8'h3C;
        tick();
        src_valid = 1'b0;
        chk_val("push_tx_count", 32'(tx_count), 32'd2);
        chk_val("push_rxf_n", 32'(rxf_n), 32'd0);
        host_read(8'hA5, "rd1");
        chk_val("rd1_tx_count", 32'(tx_count), 32'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!rxf_n) break;
            n++;
        end
        chk_val("rd1_precharge", 32'(n), 32'(PRE));
        host_read(8'h3C, "rd2");
        repeat (PRE + 3) tick();
        chk_val("rd2_tx_count", 32'(tx_count), 32'd0);
        chk_val("rd2_rxf_n", 32'(rxf_n), 32'd1);

        // Host writes, sink drains in order
        host_write(8'h11);
        host_write(8'h22);
        host_write(8'h33);
        chk_val("wr_rx_count", 32'(rx_count), 32'd3);
        chk_val("wr_snk_valid", 32'(snk_valid), 32'd1);
        chk_val("wr_err", 32'(protocol_err), 32'd0);
        snk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_val($sformatf("snk_data%0d", i), 32'(snk_data), 32'(exp_rx[i]));
            tick();
        end
        snk_ready = 1'b0;
        chk_val("snk_rx_count", 32'(rx_count), 32'd0);
        chk_val("snk_valid_low", 32'(snk_valid), 32'd0);

        // Fill RX FIFO, then overflow
        for (int i = 0; i < DEPTH; i++) host_write(8'(i + 16));
        chk_val("full_rx_count", 32'(rx_count), 32'(DEPTH));
        chk_val("full_txe_n", 32'(txe_n), 32'd1);
        chk_val("full_err_before", 32'(protocol_err), 32'd0);
        host_write(8'hEE);
        chk_val("ovf_err", 32'(protocol_err), 32'd1);
        chk_val("ovf_rx_count", 32'(rx_count), 32'(DEPTH));
        snk_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk_val($sformatf("drain%0d", i), 32'(snk_data), 32'(i + 16));
            tick();
        end
        snk_ready = 1'b0;
        chk_val("drain_rx_count", 32'(rx_count), 32'd0);

        // Read with TX FIFO empty
        apply_reset();
        chk_val("empty_err_before", 32'(protocol_err), 32'd0);
        host_read(8'h00, "empty_rd");
        chk_val("empty_err", 32'(protocol_err), 32'd1);
        chk_val("empty_tx_count", 32'(tx_count), 32'd0);

        // Simultaneous rd_n / wr_n
        apply_reset();
        push_src(8'h5A);
        repeat (2) tick();
        adbus_in = 8'h77;
        rd_n = 1'b0;
        wr_n = 1'b0;
        repeat (3) tick();
        chk_val("simul_oe", 32'(adbus_oe), 32'd1);
        chk_val("simul_data", 32'(adbus_out), 32'h5A);
        tick();
        rd_n = 1'b1;
        wr_n = 1'b1;
        repeat (PRE + 8) tick();
        chk_val("simul_tx_count", 32'(tx_count), 32'd0);
        chk_val("simul_rx_count", 32'(rx_count), 32'd0);
        chk_val("simul_err", 32'(protocol_err), 32'd1);
        chk_val("simul_txe_n", 32'(txe_n), 32'd0);

        // Reset while a read strobe is active
        apply_reset();
        push_src(8'h42);
        repeat (2) tick();
        rd_n = 1'b0;
        repeat (3) tick();
        chk_val("mid_oe", 32'(adbus_oe), 32'd1);
        chk_val("mid_data", 32'(adbus_out), 32'h42);
        reset_n = 1'b0;
        #1;
        chk_val("mid_rst_oe", 32'(adbus_oe), 32'd0);
        chk_val("mid_rst_tx_count", 32'(tx_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk_val("held_low_oe", 32'(adbus_oe), 32'd0);
        chk_val("held_low_err", 32'(protocol_err), 32'd0);
        rd_n = 1'b1;
        repeat (4) tick();
        rd_n = 1'b0;
        repeat (3) tick();
        chk_val("fresh_fall_oe", 32'(adbus_oe), 32'd1);
        chk_val("fresh_fall_err", 32'(protocol_err), 32'd1);
        rd_n = 1'b1;
        repeat (3) tick();
        chk_val("fresh_rise_oe", 32'(adbus_oe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
